// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS definitions for the ID/EX slice: ALU operation codes,
// main-decoder class codes, R-type funct values and control bundle.
package mips_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_BAD = 4'b1111
    } alu_oper_e;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'b00,
        CLS_SUB   = 2'b01,
        CLS_RTYPE = 2'b10,
        CLS_ORI   = 2'b11
    } alu_cls_e;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: instruction fields in, registered/forwarded
// execute operands and control out. master = decode side, slave = stage.
interface id_ex_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              valid_in;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [4:0]        dest_reg;
    logic [15:0]       imm;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;

    logic [DATA_W-1:0] operand_A;
    logic [DATA_W-1:0] operand_B;
    logic [3:0]        operation;
    logic [DATA_W-1:0] store_data;
    logic              valid_out;
    logic              reg_write_out;
    logic              mem_read_out;
    logic              mem_write_out;
    logic              mem_to_reg_out;
    logic [4:0]        dest_reg_out;
    logic              illegal_op;

    modport master (
        output valid_in, rs_data, rt_data, rs_addr, rt_addr, dest_reg,
        output imm, alu_op, funct, alu_src, reg_write, mem_read,
        output mem_write, mem_to_reg,
        input  operand_A, operand_B, operation, store_data, valid_out,
        input  reg_write_out, mem_read_out, mem_write_out,
        input  mem_to_reg_out, dest_reg_out, illegal_op
    );

    modport slave (
        input  valid_in, rs_data, rt_data, rs_addr, rt_addr, dest_reg,
        input  imm, alu_op, funct, alu_src, reg_write, mem_read,
        input  mem_write, mem_to_reg,
        output operand_A, operand_B, operation, store_data, valid_out,
        output reg_write_out, mem_read_out, mem_write_out,
        output mem_to_reg_out, dest_reg_out, illegal_op
    );

endinterface

// File: rtl/id_ex_stage_alu_ctrl.sv
// ALU control decoder: alu_op class + funct -> 4-bit operation.
// Ports: alu_op, funct in; operation, illegal out (combinational).
module alu_ctrl
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] operation,
    output logic       illegal
);

    always_comb begin
        operation = ALU_ADD;
        illegal   = 1'b0;
        unique case (alu_op)
            CLS_ADD: operation = ALU_ADD;
            CLS_SUB: operation = ALU_SUB;
            CLS_ORI: operation = ALU_OR;
            default: begin
                unique case (funct)
                    F_ADD:   operation = ALU_ADD;
                    F_SUB:   operation = ALU_SUB;
                    F_AND:   operation = ALU_AND;
                    F_OR:    operation = ALU_OR;
                    F_SLT:   operation = ALU_SLT;
                    F_NOR:   operation = ALU_NOR;
                    default: begin
                        operation = ALU_BAD;
                        illegal   = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU decode, immediate extension and
// EX/MEM, MEM/WB operand forwarding. Ports: clk, rst_n (sync, low),
// stall, flush, forwarding sources, and the decode/execute bus.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    id_ex_stage_if.slave      bus
);

    ctrl_t             ctrl_d, ctrl_q;
    logic [3:0]        op_d, op_q;
    logic [4:0]        rs_addr_d, rs_addr_q;
    logic [4:0]        rt_addr_d, rt_addr_q;
    logic [4:0]        dest_d, dest_q;
    logic [DATA_W-1:0] rs_data_d, rs_data_q;
    logic [DATA_W-1:0] rt_data_d, rt_data_q;
    logic [DATA_W-1:0] imm_d, imm_q;

    logic [3:0]        dec_op;
    logic              dec_illegal;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;

    alu_ctrl u_alu_ctrl (
        .alu_op    (bus.alu_op),
        .funct     (bus.funct),
        .operation (dec_op),
        .illegal   (dec_illegal)
    );

    // ori zero-extends; add/sub immediates are signed.
    always_comb begin
        if (bus.alu_op == CLS_ORI)
            imm_ext = {{(DATA_W-16){1'b0}}, bus.imm};
        else
            imm_ext = {{(DATA_W-16){bus.imm[15]}}, bus.imm};
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        op_d      = op_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        dest_d    = dest_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        if (flush || (!stall && !bus.valid_in)) begin
            ctrl_d    = CTRL_BUBBLE;
            op_d      = ALU_ADD;
            rs_addr_d = '0;
            rt_addr_d = '0;
            dest_d    = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
        end else if (!stall) begin
            ctrl_d.valid      = 1'b1;
            // An unsupported funct must never retire a register write.
            ctrl_d.reg_write  = bus.reg_write && !dec_illegal;
            ctrl_d.mem_read   = bus.mem_read;
            ctrl_d.mem_write  = bus.mem_write;
            ctrl_d.mem_to_reg = bus.mem_to_reg;
            ctrl_d.alu_src    = bus.alu_src;
            ctrl_d.illegal    = dec_illegal;
            op_d      = dec_op;
            rs_addr_d = bus.rs_addr;
            rt_addr_d = bus.rt_addr;
            dest_d    = bus.dest_reg;
            rs_data_d = bus.rs_data;
            rt_data_d = bus.rt_data;
            imm_d     = imm_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q    <= CTRL_BUBBLE;
            op_q      <= ALU_ADD;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            dest_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            op_q      <= op_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            dest_q    <= dest_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
        end
    end

    // Later assignment wins: EX/MEM overrides MEM/WB. r0 never forwards.
    always_comb begin
        rs_fwd = rs_data_q;
        rt_fwd = rt_data_q;
        if (memwb_reg_write && memwb_rd != 5'd0) begin
            if (memwb_rd == rs_addr_q) rs_fwd = memwb_result;
            if (memwb_rd == rt_addr_q) rt_fwd = memwb_result;
        end
        if (exmem_reg_write && exmem_rd != 5'd0) begin
            if (exmem_rd == rs_addr_q) rs_fwd = exmem_result;
            if (exmem_rd == rt_addr_q) rt_fwd = exmem_result;
        end
    end

    assign bus.operand_A      = rs_fwd;
    assign bus.store_data     = rt_fwd;
    assign bus.operand_B      = ctrl_q.alu_src ? imm_q : rt_fwd;
    assign bus.operation      = op_q;
    assign bus.valid_out      = ctrl_q.valid;
    assign bus.reg_write_out  = ctrl_q.reg_write;
    assign bus.mem_read_out   = ctrl_q.mem_read;
    assign bus.mem_write_out  = ctrl_q.mem_write;
    assign bus.mem_to_reg_out = ctrl_q.mem_to_reg;
    assign bus.dest_reg_out   = dest_q;
    assign bus.illegal_op     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then randomized traffic,
// checked against an instruction-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        exm_rw, mwb_rw;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_res, mwb_res;

    int tests = 0;
    int fails = 0;

    id_ex_stage_if #(.DATA_W(32)) bus ();

    id_ex_stage #(.DATA_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .exmem_reg_write (exm_rw),
        .exmem_rd        (exm_rd),
        .exmem_result    (exm_res),
        .memwb_reg_write (mwb_rw),
        .memwb_rd        (mwb_rd),
        .memwb_result    (mwb_res),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // One in-flight instruction as the execute stage should see it.
    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, src, ill;
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
    } instr_t;

    instr_t m;
    logic [3:0] fmap [logic [5:0]];
    logic [5:0] flist [6];

    function automatic instr_t bubble();
        instr_t e;
        e = '0;
        e.op = 4'b0010;
        return e;
    endfunction

    function automatic instr_t capture();
        instr_t e;
        e = '0;
        e.valid = 1'b1;
        e.rw  = bus.reg_write;
        e.mr  = bus.mem_read;
        e.mw  = bus.mem_write;
        e.m2r = bus.mem_to_reg;
        e.src = bus.alu_src;
        e.rs  = bus.rs_addr;
        e.rt  = bus.rt_addr;
        e.rd  = bus.dest_reg;
        e.a   = bus.rs_data;
        e.b   = bus.rt_data;
        case (bus.alu_op)
            2'b00: e.op = 4'b0010;
            2'b01: e.op = 4'b0110;
            2'b11: e.op = 4'b0001;
            default:
                if (fmap.exists(bus.funct)) begin
                    e.op = fmap[bus.funct];
                end else begin
                    e.op  = 4'b1111;
                    e.ill = 1'b1;
                    e.rw  = 1'b0;
                end
        endcase
        if (bus.alu_op == 2'b11) e.imm = {16'h0, bus.imm};
        else e.imm = {{16{bus.imm[15]}}, bus.imm};
        return e;
    endfunction

    function automatic instr_t next_state();
        if (!rst_n) return bubble();
        if (flush) return bubble();
        if (stall) return m;
        if (!bus.valid_in) return bubble();
        return capture();
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] v);
        if (exm_rw && exm_rd != 0 && exm_rd == r) return exm_res;
        if (mwb_rw && mwb_rd != 0 && mwb_rd == r) return mwb_res;
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string t);
        logic [31:0] es;
        es = fwd(m.rt, m.b);
        chk({t, ".valid"}, 32'(bus.valid_out), 32'(m.valid));
        chk({t, ".rw"}, 32'(bus.reg_write_out), 32'(m.rw));
        chk({t, ".mr"}, 32'(bus.mem_read_out), 32'(m.mr));
        chk({t, ".mw"}, 32'(bus.mem_write_out), 32'(m.mw));
        chk({t, ".m2r"}, 32'(bus.mem_to_reg_out), 32'(m.m2r));
        chk({t, ".ill"}, 32'(bus.illegal_op), 32'(m.ill));
        chk({t, ".op"}, 32'(bus.operation), 32'(m.op));
        if (m.valid) begin
            chk({t, ".rd"}, 32'(bus.dest_reg_out), 32'(m.rd));
            chk({t, ".A"}, bus.operand_A, fwd(m.rs, m.a));
            chk({t, ".B"}, bus.operand_B, m.src ? m.imm : es);
            chk({t, ".st"}, bus.store_data, es);
        end
    endtask

    task automatic tick();
        instr_t n;
        n = next_state();
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic no_fwd();
        exm_rw = 0; exm_rd = 0; exm_res = 0;
        mwb_rw = 0; mwb_rd = 0; mwb_res = 0;
    endtask

    task automatic set_instr(logic [1:0] op, logic [5:0] fn,
                             logic [4:0] rs, logic [31:0] rsv,
                             logic [4:0] rt, logic [31:0] rtv,
                             logic [15:0] im, logic src);
        bus.valid_in = 1; bus.alu_op = op; bus.funct = fn;
        bus.rs_addr = rs; bus.rs_data = rsv;
        bus.rt_addr = rt; bus.rt_data = rtv;
        bus.imm = im; bus.alu_src = src; bus.dest_reg = 5'd9;
        bus.reg_write = 1; bus.mem_read = 0;
        bus.mem_write = 0; bus.mem_to_reg = 0;
    endtask

    task automatic rand_instr();
        bus.valid_in = ($urandom_range(0, 9) < 8);
        bus.alu_op = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) < 7) bus.funct = flist[$urandom_range(0, 5)];
        else bus.funct = 6'($urandom);
        bus.rs_addr = 5'($urandom_range(0, 7));
        bus.rt_addr = 5'($urandom_range(0, 7));
        bus.dest_reg = 5'($urandom);
        bus.rs_data = $urandom; bus.rt_data = $urandom;
        bus.imm = 16'($urandom);
        bus.alu_src = (bus.alu_op == 2'b10) ? 1'b0 : 1'($urandom);
        bus.reg_write = 1'($urandom); bus.mem_read = 1'($urandom);
        bus.mem_write = 1'($urandom); bus.mem_to_reg = 1'($urandom);
    endtask

    task automatic rand_fwd();
        exm_rw = 1'($urandom); exm_rd = 5'($urandom_range(0, 7));
        exm_res = $urandom;
        mwb_rw = 1'($urandom); mwb_rd = 5'($urandom_range(0, 7));
        mwb_res = $urandom;
    endtask

    initial begin
        fmap[6'b100000] = 4'b0010; fmap[6'b100010] = 4'b0110;
        fmap[6'b100100] = 4'b0000; fmap[6'b100101] = 4'b0001;
        fmap[6'b101010] = 4'b0111; fmap[6'b100111] = 4'b1100;
        flist = '{6'b100000, 6'b100010, 6'b100100,
                  6'b100101, 6'b101010, 6'b100111};
        m = bubble();
        rst_n = 0; stall = 0; flush = 0;
        no_fwd();
        set_instr(2'b00, 6'd0, 5'd0, 0, 5'd0, 0, 16'd0, 0);
        tick(); tick();
        check_all("reset");
        chk("reset.opcode", 32'(bus.operation), 32'h2);
        rst_n = 1;

        set_instr(2'b10, 6'b100000, 5'd5, 32'd7, 5'd6, 32'd3, 16'd0, 0);
        tick();
        check_all("radd");
        chk("radd.A", bus.operand_A, 32'd7);
        chk("radd.B", bus.operand_B, 32'd3);

        exm_rw = 1; exm_rd = 5; exm_res = 100;
        mwb_rw = 1; mwb_rd = 5; mwb_res = 200;
        #1; chk("fwd.both", bus.operand_A, 32'd100);
        exm_rw = 0;
        #1; chk("fwd.memwb", bus.operand_A, 32'd200);
        check_all("fwd");

        no_fwd();
        set_instr(2'b10, 6'b100010, 5'd0, 32'd9, 5'd0, 32'd4, 16'd0, 0);
        tick();
        exm_rw = 1; exm_rd = 0; exm_res = 55;
        #1; chk("r0.A", bus.operand_A, 32'd9);
        check_all("r0");

        no_fwd();
        set_instr(2'b00, 6'd0, 5'd1, 1, 5'd2, 2, 16'hFFFC, 1);
        tick();
        chk("sext.B", bus.operand_B, 32'hFFFFFFFC);
        check_all("sext");
        set_instr(2'b11, 6'd0, 5'd1, 1, 5'd2, 2, 16'hFFFC, 1);
        tick();
        chk("zext.B", bus.operand_B, 32'h0000FFFC);
        chk("zext.op", 32'(bus.operation), 32'h1);
        check_all("zext");

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_instr();
            tick();
            chk("stall.B", bus.operand_B, 32'h0000FFFC);
            check_all("stall");
        end
        flush = 1;
        tick();
        chk("flush.valid", 32'(bus.valid_out), 32'h0);
        chk("flush.rw", 32'(bus.reg_write_out), 32'h0);
        check_all("flush");
        stall = 0; flush = 0;

        set_instr(2'b10, 6'b000011, 5'd3, 3, 5'd4, 4, 16'd0, 0);
        tick();
        chk("ill.op", 32'(bus.operation), 32'hF);
        chk("ill.flag", 32'(bus.illegal_op), 32'h1);
        chk("ill.rw", 32'(bus.reg_write_out), 32'h0);
        check_all("ill");
        rst_n = 0; stall = 1;
        tick();
        chk("rst.op", 32'(bus.operation), 32'h2);
        chk("rst.A", bus.operand_A, 32'h0);
        check_all("rst");
        rst_n = 1; stall = 0;

        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rand_instr();
            rand_fwd();
            tick();
            check_all("rand");
            rand_fwd();
            #1;
            check_all("randfwd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
